jam_eval_sched: RTL and testbench

- Shared permutation-cost evaluator for the job-assignment datapath.
- Arbitrates the single 8x8 cost-ROM read port (W/J in, Cost out) between NREQ search engines.
- Each engine submits a full worker->job permutation. The block sequences 8 ROM reads, accumulates the total cost, and returns it tagged with the requester id.
- Sits between the permutation generators and the cost ROM; lets several generators share one ROM.

---
 rtl/jam_eval_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_jam_eval_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jam_eval_sched.sv
// jam_eval_sched: shares the single 8x8 cost-ROM read port between NREQ
// permutation generators. A granted permutation is captured, its eight
// (worker, job) costs are read one per cycle and summed, and the total is
// returned with the requester id.
// Optional build macro: JAM_PERM_CHECK_EN enables a job-distinctness check at
// capture; an invalid permutation skips the ROM walk and reports sum=all-ones
// with err=1. Without the macro err is tied low.
module jam_eval_sched #(
    parameter int NREQ = 2,
    parameter int CW   = 7,
    parameter int SW   = 10,
    parameter int IDW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req,
    input  logic [24*NREQ-1:0]   perm,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           W,
    output logic [2:0]           J,
    input  logic [CW-1:0]        Cost,
    output logic [NREQ-1:0]      done,
    output logic [SW-1:0]        sum,
    output logic [IDW-1:0]       sum_id,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    idx_q, idx_d;
    logic [23:0]       perm_q, perm_d;
    logic [SW-1:0]     acc_q, acc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        w_q, w_d;
    logic [2:0]        j_q, j_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [IDW-1:0]    sum_id_q, sum_id_d;
    logic              err_q, err_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;

    logic              arb_found_s;
    logic [IDW-1:0]    arb_idx_s;
    logic [23:0]       perm_sel_s;
    logic              perm_ok_s;
    logic [SW-1:0]     acc_next_s;
    int                cand_s;

    // Job field k of a packed permutation (bits [3k+2:3k]).
    function automatic logic [2:0] job_field(input logic [23:0] p, input logic [2:0] k);
        logic [2:0] f;
        case (k)
            3'd0:    f = p[2:0];
            3'd1:    f = p[5:3];
            3'd2:    f = p[8:6];
            3'd3:    f = p[11:9];
            3'd4:    f = p[14:12];
            3'd5:    f = p[17:15];
            3'd6:    f = p[20:18];
            3'd7:    f = p[23:21];
            default: f = 3'd0;
        endcase
        return f;
    endfunction

`ifdef JAM_PERM_CHECK_EN
    // A permutation is valid only if every job 0..7 appears exactly once.
    function automatic logic perm_is_valid(input logic [23:0] p);
        logic [7:0] seen;
        seen = 8'd0;
        for (int k = 0; k < 8; k++) begin
            seen[job_field(p, 3'(k))] = 1'b1;
        end
        return &seen;
    endfunction

    assign perm_ok_s = perm_is_valid(perm_sel_s);
`else
    assign perm_ok_s = 1'b1;
`endif

    // Round-robin pick: first asserted req scanning from rr_ptr upward, wrapping at NREQ.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        cand_s      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = int'(rr_ptr_q) + i;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!arb_found_s && req[cand_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = IDW'(cand_s);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    assign perm_sel_s = perm[24*int'(arb_idx_s) +: 24];
    assign acc_next_s = acc_q + SW'(Cost);

    // Grant is a same-cycle acknowledge from IDLE; forced low while reset is asserted.
    always_comb begin
        gnt = '0;
        if (RST_N && (state_q == S_IDLE) && arb_found_s) begin
            gnt = NREQ'(1'b1) << arb_idx_s;
        end else begin
            gnt = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            perm_q   <= 24'd0;
            acc_q    <= '0;
            cnt_q    <= 3'd0;
            w_q      <= 3'd0;
            j_q      <= 3'd0;
            sum_q    <= '0;
            sum_id_q <= '0;
            err_q    <= 1'b0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            perm_q   <= perm_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            j_q      <= j_d;
            sum_q    <= sum_d;
            sum_id_q <= sum_id_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: IDLE -> READ (8 cycles) -> RESP -> IDLE; invalid perm jumps to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found_s) begin
                    state_d = perm_ok_s ? S_READ : S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_READ;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath/output next values; outputs are loaded so they are valid in the RESP cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        perm_d   = perm_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        w_d      = 3'd0;
        j_d      = 3'd0;
        sum_d    = sum_q;
        sum_id_d = sum_id_q;
        err_d    = 1'b0;
        done_d   = '0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (arb_found_s) begin
                    idx_d  = arb_idx_s;
                    perm_d = perm_sel_s;
                    acc_d  = '0;
                    cnt_d  = 3'd0;
                    if (perm_ok_s) begin
                        w_d = 3'd0;
                        j_d = job_field(perm_sel_s, 3'd0);
                    end else begin
                        sum_d    = '1;
                        sum_id_d = arb_idx_s;
                        err_d    = 1'b1;
                        done_d   = NREQ'(1'b1) << arb_idx_s;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_READ: begin
                acc_d = acc_next_s;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    sum_d    = acc_next_s;
                    sum_id_d = idx_q;
                    done_d   = NREQ'(1'b1) << idx_q;
                end else begin
                    w_d = cnt_q + 3'd1;
                    j_d = job_field(perm_q, cnt_q + 3'd1);
                end
            end
            S_RESP: begin
                if (int'(idx_q) + 1 >= NREQ) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = idx_q + IDW'(1'b1);
                end
            end
            default: begin
                rr_ptr_d = '0;
            end
        endcase
    end

    assign W      = w_q;
    assign J      = j_q;
    assign sum    = sum_q;
    assign sum_id = sum_id_q;
    assign err    = err_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_jam_eval_sched.sv
// Directed bench for jam_eval_sched (NREQ=2, CW=7, SW=10, IDW=2).
// The cost ROM is modelled combinationally: Cost = W*J, or 127 everywhere.
module tb_jam_eval_sched;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  req;
    logic [47:0] perm;
    logic [1:0]  gnt;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic [1:0]  done;
    logic [9:0]  sum;
    logic [1:0]  sum_id;
    logic        busy;
    logic        err;
    logic        cost_max;

    int checks;
    int failures;

    jam_eval_sched #(.NREQ(2), .CW(7), .SW(10), .IDW(2)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .req    (req),
        .perm   (perm),
        .gnt    (gnt),
        .W      (W),
        .J      (J),
        .Cost   (Cost),
        .done   (done),
        .sum    (sum),
        .sum_id (sum_id),
        .busy   (busy),
        .err    (err)
    );

    assign Cost = cost_max ? 7'd127 : (7'(W) * 7'(J));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] mk_perm(input bit rev);
        logic [23:0] p;
        p = 24'd0;
        for (int k = 0; k < 8; k++) begin
            p[3*k +: 3] = rev ? 3'(7 - k) : 3'(k);
        end
        return p;
    endfunction

    task automatic next_cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_W"}, 32'(W), 32'd0);
        chk({tag, "_J"}, 32'(J), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_sum_id"}, 32'(sum_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // One complete evaluation for requester id; checks the W/J walk and the result.
    task automatic run_single(input int id, input bit rev, input logic [9:0] exp_sum, input string tag);
        logic [23:0] p;
        int n;
        p = mk_perm(rev);
        @(negedge CLK);
        perm[24*id +: 24] = p;
        req[id] = 1'b1;
        #1;
        n = 0;
        while (gnt[id] !== 1'b1 && n < 20) begin
            next_cyc();
            n++;
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(2'b01 << id));
        @(negedge CLK);
        req[id] = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_W"}, 32'(W), 32'(k));
            chk({tag, "_J"}, 32'(J), rev ? 32'(7 - k) : 32'(k));
            chk({tag, "_busy_rd"}, 32'(busy), 32'd1);
            chk({tag, "_done_rd"}, 32'(done), 32'd0);
            if (k < 7) begin
                next_cyc();
            end else begin
                next_cyc();
            end
        end
        chk({tag, "_done"}, 32'(done), 32'(2'b01 << id));
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_sum_id"}, 32'(sum_id), 32'(id));
        chk({tag, "_err"}, 32'(err), 32'd0);
        next_cyc();
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int gcount;
        int dcount;
        int last_g;
        checks   = 0;
        failures = 0;
        req      = 2'b00;
        perm     = 48'd0;
        cost_max = 1'b0;
        RST_N    = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check_reset_vals("rst_idle");

        // Identity on W*J: sum of k^2 = 140.
        run_single(0, 1'b0, 10'd140, "id0");
        // Reverse on W*J: sum k*(7-k) = 56.
        run_single(1, 1'b1, 10'd56, "rev1");
        // Max cost everywhere: 8*127 = 1016 fits in 10 bits.
        cost_max = 1'b1;
        run_single(0, 1'b0, 10'd1016, "max0");
        cost_max = 1'b0;

        // Fairness: both requesters held after reset -> grants 0,1,0,1 every 10 cycles.
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        perm  = {mk_perm(1'b1), mk_perm(1'b0)};
        req   = 2'b11;
        #1;
        gcount = 0;
        dcount = 0;
        last_g = 0;
        for (int c = 0; c < 40; c++) begin
            if (gnt != 2'b00) begin
                chk("rr_gnt", 32'(gnt), (gcount % 2 == 0) ? 32'd1 : 32'd2);
                if (gcount > 0) begin
                    chk("rr_spacing", 32'(c - last_g), 32'd10);
                end else begin
                    chk("rr_first", 32'(c), 32'd0);
                end
                last_g = c;
                gcount++;
            end
            if (done != 2'b00) begin
                chk("rr_done", 32'(done), (dcount % 2 == 0) ? 32'd1 : 32'd2);
                chk("rr_sum_id", 32'(sum_id), 32'(dcount % 2));
                chk("rr_sum", 32'(sum), (dcount % 2 == 0) ? 32'd140 : 32'd56);
                dcount++;
            end
            next_cyc();
        end
        req = 2'b00;
        chk("rr_gcount", 32'(gcount), 32'd4);
        chk("rr_dcount", 32'(dcount), 32'd4);
        repeat (12) next_cyc();

        // Reset during READ cycle 4 aborts with no done; re-request completes normally.
        @(negedge CLK);
        perm[23:0] = mk_perm(1'b0);
        req[0] = 1'b1;
        #1;
        chk("abort_gnt", 32'(gnt), 32'd1);
        @(negedge CLK);
        req[0] = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        chk("abort_W_pre", 32'(W), 32'd3);
        RST_N = 1'b0;
        #1;
        check_reset_vals("abort_rst");
        for (int c = 0; c < 12; c++) begin
            if (c == 2) begin
                RST_N = 1'b1;
            end else begin
                RST_N = RST_N;
            end
            chk("abort_no_done", 32'(done), 32'd0);
            next_cyc();
        end
        run_single(0, 1'b0, 10'd140, "retry0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
